// File: rtl/lsu_mem_ctrl.sv
// Load/store access controller: alignment check, store lane steering and byte enables,
// req/ack handshake with a variable-latency data memory, and access timeout.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [1:0]  rsp_err,
  output logic [31:0] ld_data,
  output logic [1:0]  addr,
  output logic        lh_en,
  output logic        lb_en,
  output logic        ld_unsigned
);

  localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          mem_req_q, mem_we_q;
  logic [31:0]   mem_addr_q, mem_wdata_q;
  logic [3:0]    mem_be_q;
  logic          rsp_valid_q;
  logic [1:0]    rsp_err_q;
  logic [31:0]   ld_data_q;
  logic [1:0]    rsp_addr_q;
  logic          rsp_lh_q, rsp_lb_q, rsp_uns_q;
  logic          p_we_q, p_lh_q, p_lb_q, p_uns_q;
  logic [1:0]    p_addr_q;

  logic          bad_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic          lh_d, lb_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bad_d   = 1'b0;
    be_d    = 4'b0000;
    wdata_d = req_wdata;
    unique case (req_size)
      2'd0: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
        bad_d   = req_addr[0];
      end
      2'd2: begin
        be_d  = 4'b1111;
        bad_d = (req_addr[1:0] != 2'b00);
      end
      default: bad_d = 1'b1;
    endcase
    lh_d = !req_we && (req_size == 2'd1);
    lb_d = !req_we && (req_size == 2'd0);
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
      ld_data_q   <= '0;
      rsp_addr_q  <= '0;
      rsp_lh_q    <= 1'b0;
      rsp_lb_q    <= 1'b0;
      rsp_uns_q   <= 1'b0;
      p_we_q      <= 1'b0;
      p_lh_q      <= 1'b0;
      p_lb_q      <= 1'b0;
      p_uns_q     <= 1'b0;
      p_addr_q    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (req_valid) begin
          p_we_q   <= req_we;
          p_lh_q   <= lh_d;
          p_lb_q   <= lb_d;
          p_uns_q  <= req_unsigned;
          p_addr_q <= req_addr[1:0];
          if (bad_d) begin
            // Rejected accesses never touch memory and respond on the next cycle.
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= ERR_ALIGN;
            ld_data_q   <= '0;
            rsp_addr_q  <= req_addr[1:0];
            rsp_lh_q    <= lh_d;
            rsp_lb_q    <= lb_d;
            rsp_uns_q   <= req_unsigned;
          end else begin
            state_q     <= ST_ACCESS;
            cnt_q       <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we;
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            mem_wdata_q <= wdata_d;
            mem_be_q    <= be_d;
          end
        end
        ST_ACCESS: begin
          if (mem_ack || (cnt_q == CNT_LAST)) begin
            state_q     <= ST_RESP;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_addr_q  <= p_addr_q;
            rsp_lh_q    <= p_lh_q;
            rsp_lb_q    <= p_lb_q;
            rsp_uns_q   <= p_uns_q;
            // An ack on the final allowed cycle still completes the access.
            rsp_err_q   <= mem_ack ? ERR_OK : ERR_TIMEOUT;
            ld_data_q   <= (mem_ack && !p_we_q) ? mem_rdata : 32'd0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_be      = mem_be_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign ld_data     = ld_data_q;
  assign addr        = rsp_addr_q;
  assign lh_en       = rsp_lh_q;
  assign lb_en       = rsp_lb_q;
  assign ld_unsigned = rsp_uns_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed scenarios plus randomized accesses
// checked against an arithmetic reference model of alignment, steering and timing.
module tb_lsu_mem_ctrl;

  localparam int TO = 16;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, lh_en, lb_en, ld_unsigned;
  logic [1:0]  rsp_err, addr;
  logic [31:0] ld_data;

  int checks = 0;
  int errors = 0;

  lsu_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .ld_data(ld_data), .addr(addr),
    .lh_en(lh_en), .lb_en(lb_en), .ld_unsigned(ld_unsigned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {30'b0, rsp_err}, 32'd0);
    check("rst_ld_data", ld_data, 32'd0);
    check("rst_addr", {30'b0, addr}, 32'd0);
    check("rst_lh_lb_uns", {29'b0, lh_en, lb_en, ld_unsigned}, 32'd0);
  endtask

  // Reference model: byte count from size, alignment by modulo, lanes by shifting a mask.
  function automatic logic model_bad(input logic [1:0] size, input logic [31:0] a);
    if (size == 2'd3) return 1'b1;
    return (int'(a[1:0]) % (1 << size)) != 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    int bytes;
    bytes = 1 << size;
    return 4'(((1 << bytes) - 1) << ((int'(a[1:0]) / bytes) * bytes));
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return {24'b0, wd[7:0]} * 32'h0101_0101;
    if (size == 2'd1) return {16'b0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  task automatic check_mem(input logic we, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] wd);
    check("mem_req", {31'b0, mem_req}, 32'd1);
    check("mem_we", {31'b0, mem_we}, {31'b0, we});
    check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
    check("mem_wdata", mem_wdata, model_wdata(size, wd));
    check("mem_be", {28'b0, mem_be}, {28'b0, model_be(size, a)});
    check("wait_ready", {30'b0, req_ready, rsp_valid}, 32'd0);
  endtask

  // One complete access; delay = ACCESS cycles before ack (>= TO means never ack).
  task automatic do_access(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int delay, input logic [31:0] rd);
    logic [1:0]  err;
    logic [31:0] ldx;
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    check("accept_ready", {31'b0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_addr = $urandom; req_wdata = $urandom;
    if (model_bad(size, a)) begin
      err = 2'd1;
      ldx = 32'd0;
      check("err_no_mem_req", {31'b0, mem_req}, 32'd0);
    end else begin
      for (int c = 0; c < TO && c < delay; c++) begin
        check_mem(we, size, a, wd);
        tick();
      end
      if (delay < TO) begin
        check_mem(we, size, a, wd);
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; mem_rdata = $urandom;
        err = 2'd0;
        ldx = we ? 32'd0 : rd;
      end else begin
        err = 2'd2;
        ldx = 32'd0;
      end
      check("rsp_mem_req_low", {31'b0, mem_req}, 32'd0);
    end
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("rsp_err", {30'b0, rsp_err}, {30'b0, err});
    check("ld_data", ld_data, ldx);
    check("rsp_addr", {30'b0, addr}, {30'b0, a[1:0]});
    check("lh_en", {31'b0, lh_en}, {31'b0, !we && size == 2'd1});
    check("lb_en", {31'b0, lb_en}, {31'b0, !we && size == 2'd0});
    check("ld_unsigned", {31'b0, ld_unsigned}, {31'b0, uns});
    check("resp_not_ready", {31'b0, req_ready}, 32'd0);
    tick();
    check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
    check("back_idle_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    int          r_delay;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    #12;
    check_reset_state();
    tick();
    rst_n = 1'b1;
    tick();
    check_reset_state();

    // SB, minimum latency
    do_access(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0);
    // LH with three wait cycles
    do_access(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'hDEAD_BEEF, 3, 32'h8001_1234);
    // misaligned word and illegal size
    do_access(1'b0, 2'd2, 1'b0, 32'h0000_3001, 32'h0, 0, 32'h0);
    do_access(1'b1, 2'd3, 1'b1, 32'h0000_4000, 32'h1234_5678, 0, 32'h0);
    // ack on the last allowed cycle, then a full timeout
    do_access(1'b0, 2'd2, 1'b1, 32'h0000_5000, 32'h0, TO - 1, 32'hCAFE_F00D);
    do_access(1'b0, 2'd0, 1'b1, 32'h0000_6001, 32'h0, TO, 32'h1111_2222);

    // late ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    tick();
    tick();
    mem_ack = 1'b0;
    check("late_ack_ready", {31'b0, req_ready}, 32'd1);
    check("late_ack_no_rsp", {30'b0, rsp_valid, mem_req}, 32'd0);
    check("late_ack_ld_data", ld_data, 32'd0);

    // reset asserted mid-access
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h0000_0400;
    req_wdata = 32'h0BAD_0BAD;
    tick();
    req_valid = 1'b0;
    tick();
    check("pre_rst_mem_req", {31'b0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    tick();
    check("in_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);
    do_access(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1357_9BDF, 1, 32'h0);

    // back-to-back with req_valid held: second request waits for RESP to finish
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0000_0100; req_wdata = 32'h0;
    tick();
    req_we = 1'b1; req_size = 2'd0; req_addr = 32'h0000_0205; req_wdata = 32'h0000_005A;
    check_mem(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    tick();
    check_mem(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h0102_0304;
    tick();
    mem_ack = 1'b0;
    check("b2b_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b_ld_data", ld_data, 32'h0102_0304);
    check("b2b_resp_not_ready", {31'b0, req_ready}, 32'd0);
    tick();
    check("b2b_idle_ready", {31'b0, req_ready}, 32'd1);
    check("b2b_idle_no_req", {30'b0, mem_req, rsp_valid}, 32'd0);
    tick();
    req_valid = 1'b0;
    check_mem(1'b1, 2'd0, 32'h0000_0205, 32'h0000_005A);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("b2b2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b2_rsp_err", {30'b0, rsp_err}, 32'd0);
    tick();

    // randomized accesses
    for (int n = 0; n < 60; n++) begin
      r_we   = 1'($urandom);
      r_uns  = 1'($urandom);
      r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = $urandom;
      if ($urandom_range(0, 2) != 0) r_addr[1:0] = r_addr[1:0] & ~2'((1 << r_size) - 1);
      r_delay = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2)
                                            : $urandom_range(0, 4);
      do_access(r_we, r_size, r_uns, r_addr, $urandom, r_delay, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
